// File: rtl/ram_bidir_32x32.sv
// ram_bidir_32x32: 32x32 single-port RAM on a shared tri-state bus.
// Synchronous write, combinational read, asynchronous clear.
module ram_bidir_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  wena,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data_io
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (ena && wena)
      mem[addr] <= data_io;
  // drive only on an enabled read so the external master never contends
  assign data_io = (ena && !wena) ? mem[addr] : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_ram_bidir_32x32.sv
// tb_ram_bidir_32x32: scoreboard bench for the bidirectional 32x32 RAM.
module tb_ram_bidir_32x32;
  logic clk = 0, rst = 0, ena = 0, wena = 0, drv_en = 0;
  logic [4:0] addr = '0;
  logic [31:0] drv = '0, got, exp;
  wire  [31:0] data_io;
  logic [31:0] sb [$];
  logic [31:0] model [32];
  int checks = 0, passed = 0;
  localparam logic [31:0] ZZ = 32'bz;

  assign data_io = drv_en ? drv : ZZ;
  always #5 clk = ~clk;

  ram_bidir_32x32 dut (.clk(clk), .rst(rst), .ena(ena), .wena(wena), .addr(addr), .data_io(data_io));

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    ena = 1; wena = 1; addr = a; drv = d; drv_en = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    drv_en = 0; ena = 1; wena = 0; addr = a;
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    ena = 0;
    sb.push_back(ZZ);
    #1;
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL reset_idle_z got=%h exp=%h", got, exp); else passed++;
    sb.push_back(32'h0);
    rd(5);
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL reset_read5 got=%h exp=%h", got, exp); else passed++;
  endtask

  task automatic test_write_read;
    wr(0, 32'hFFFFFFFF);
    wr(4, 32'hFF00FF00);
    sb.push_back(32'hFF00FF00);
    rd(4);
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL wr_rd_addr4 got=%h exp=%h", got, exp); else passed++;
    sb.push_back(32'hFFFFFFFF);
    rd(0);
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL wr_rd_addr0 got=%h exp=%h", got, exp); else passed++;
  endtask

  task automatic test_turnaround;
    @(negedge clk);
    sb.push_back(32'h0);
    rd(5);
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL turn_pre got=%h exp=%h", got, exp); else passed++;
    wena = 1; drv = 32'hFFF0FFF0; drv_en = 1;
    sb.push_back(32'hFFF0FFF0);
    #1;
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL turn_no_contention got=%h exp=%h", got, exp); else passed++;
    @(posedge clk);
    #1;
    sb.push_back(32'hFFF0FFF0);
    rd(5);
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL turn_readback got=%h exp=%h", got, exp); else passed++;
  endtask

  task automatic test_disable;
    @(negedge clk);
    ena = 0;
    sb.push_back(ZZ);
    #1;
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL dis_z got=%h exp=%h", got, exp); else passed++;
    addr = 6;
    sb.push_back(ZZ);
    #1;
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL dis_addr6_z got=%h exp=%h", got, exp); else passed++;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(32'hFFFFFFFF);
    rd(0);
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL dis_retained got=%h exp=%h", got, exp); else passed++;
    @(negedge clk);
    wena = 1;
    sb.push_back(ZZ);
    #1;
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL wena_release_z got=%h exp=%h", got, exp); else passed++;
  endtask

  task automatic test_write_gating;
    @(negedge clk);
    ena = 0; wena = 1; addr = 7; drv = 32'h12345678; drv_en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sb.push_back(32'h0);
    rd(7);
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL gate_addr7 got=%h exp=%h", got, exp); else passed++;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 32; i++) begin
      model[i] = $urandom;
      wr(5'(i), model[i]);
      sb.push_back(model[i]);
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i));
      got = data_io; exp = sb.pop_front(); checks++;
      if (got !== exp) $display("FAIL b2b_addr%0d got=%h exp=%h", i, got, exp); else passed++;
    end
  endtask

  task automatic test_async_reset;
    wr(31, 32'hA5A5A5A5);
    sb.push_back(32'hA5A5A5A5);
    rd(31);
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL ar_pre got=%h exp=%h", got, exp); else passed++;
    @(negedge clk);
    #2;
    rst = 1;
    sb.push_back(32'h0);
    #1;
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL ar_immediate got=%h exp=%h", got, exp); else passed++;
    wena = 1; drv = 32'hDEADBEEF; drv_en = 1;
    @(posedge clk);
    #1;
    sb.push_back(32'h0);
    rd(31);
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL ar_write_blocked_rst got=%h exp=%h", got, exp); else passed++;
    @(negedge clk);
    rst = 0;
    sb.push_back(32'h0);
    #1;
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL ar_write_blocked got=%h exp=%h", got, exp); else passed++;
    sb.push_back(32'h0);
    rd(0);
    got = data_io; exp = sb.pop_front(); checks++;
    if (got !== exp) $display("FAIL ar_cleared_addr0 got=%h exp=%h", got, exp); else passed++;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_turnaround;
    test_disable;
    test_write_gating;
    test_back_to_back;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ram_bidir_32x32.md
Name: ram_bidir_32x32

Overview:
- Single-port 32-word x 32-bit RAM with one bidirectional tri-state data bus.
- Writes are synchronous to clk. Reads are combinational.
- The block drives the bus only during an enabled read. Otherwise it releases the bus to the external driver.
- Used as a small register-file/scratch memory behind a shared bus.

Parameters:
- DATA_WIDTH, 32, width of each word and of data_io.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH = 32 words.

Ports:
- clk  input  1  sole clock; write on rising edge.
- rst  input  1  asynchronous, active-high reset; clears all words.
- ena  input  1  chip enable; 0 = block idle, bus released.
- wena  input  1  1 = write cycle (external drives bus), 0 = read cycle (block drives bus).
- addr  input  ADDR_WIDTH  word address, 0..31.
- data_io  inout  DATA_WIDTH  shared data bus.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Storage: DEPTH x DATA_WIDTH array.
- Reset:
  - rst rising clears every word to 0 immediately, without waiting for clk.
  - While rst = 1, all words are held at 0 and writes are ignored.
- Write:
  - Condition: rising edge of clk with rst = 0, ena = 1, wena = 1.
  - Action: mem[addr] <= data_io.
  - Exactly one word is updated per edge.
  - The value on the bus at the edge is captured, even if it is X or Z; the bench must not rely on Z capture.
- Read:
  - When ena = 1 and wena = 0, data_io = mem[addr] combinationally.
  - Zero-cycle latency. The bus follows addr changes and completed writes within the same delta cycle.
  - While rst = 1, a read returns 0.
- Bus release:
  - When ena = 0, data_io = all Z, regardless of wena and addr.
  - When wena = 1, data_io = all Z; the external master drives it.
  - The block never drives the bus while wena = 1. This avoids contention.
- Write-then-read:
  - After the write edge, dropping wena makes the new value appear on the bus with no extra cycle.
- Address coverage: all 32 addresses are valid. There is no out-of-range case because addr is exactly ADDR_WIDTH bits.
- Unwritten words read 0 after reset.
- Words hold their contents indefinitely while ena = 0.
- Simultaneous events:
  - rst has priority over a coincident clk write.
  - Changing addr or data_io at the clk edge uses the pre-edge sampled values (standard nonblocking semantics).

Test Plan:
- Reset and idle: assert rst, then release it. With ena = 0 -> data_io = Z. With ena = 1, wena = 0, addr = 5 -> data_io = 32'h00000000.
- Basic write/read:
  - ena = 1, wena = 1, addr = 0; drive 32'hFFFFFFFF for one clk edge.
  - Set addr = 4; drive 32'hFF00FF00 for one edge.
  - Release the bus and set wena = 0 -> data_io = 32'hFF00FF00 immediately.
  - Set addr = 0 -> data_io = 32'hFFFFFFFF.
- Read/write turnaround:
  - wena = 0, addr = 5 -> data_io = 0.
  - wena = 1, drive 32'hFFF0FFF0, wait one edge.
  - wena = 0 -> data_io = 32'hFFF0FFF0, with no bus contention (no X) at any point.
- Disable:
  - After the writes above, ena = 0 -> data_io = Z.
  - Change addr to 6 -> still Z.
  - Re-enable (ena = 1, wena = 0, addr = 0) -> 32'hFFFFFFFF retained.
- Write gating: ena = 0, wena = 1, drive 32'h12345678 to addr 7 over several edges; then read addr 7 -> 32'h00000000.
- Async reset mid-operation: write 32'hA5A5A5A5 to addr 31. Assert rst between clk edges -> read of addr 31 returns 0 at once, and a write attempted while rst = 1 is not stored.
